adder_rr_arbiter: RTL and testbench

ADDER_RR_ARBITER -- requirements
Module: adder_rr_arbiter

---
 rtl/adder_rr_arbiter.sv | 86 ++++++++
 tb/tb_adder_rr_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: NUM_REQ requesters share one 32-bit adder through a
// round-robin arbiter. The result sits in a single registered response slot
// that a new grant may refill in the same cycle it is drained.
module adder_rr_arbiter #(
   parameter  int NUM_REQ = 4,
   parameter  int DATA_W  = 32,
   localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [NUM_REQ-1:0]        i_req_valid,
   output logic [NUM_REQ-1:0]        o_req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] i_req_a,
   input  logic [NUM_REQ*DATA_W-1:0] i_req_b,
   output logic                      o_rsp_valid,
   input  logic                      i_rsp_ready,
   output logic [DATA_W-1:0]         o_rsp_sum,
   output logic [ID_W-1:0]           o_rsp_id,
   output logic                      o_rsp_ovf,
   output logic [15:0]               o_grant_cnt
);

   // operands viewed per requester
   logic [NUM_REQ-1:0][DATA_W-1:0] req_a_arr, req_b_arr;
   assign req_a_arr = i_req_a;
   assign req_b_arr = i_req_b;

   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   gnt_idx;
   logic [ID_W-1:0]   ptr_nxt;
   logic              gnt_found;
   logic              slot_free;
   logic              gnt_en;
   logic [DATA_W-1:0] a_sel, b_sel, sum;
   logic              ovf;

   // first valid requester scanning ptr, ptr+1, ... with wraparound
   always_comb begin
      int j;
      j         = 0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = int'(ptr) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!gnt_found && i_req_valid[j]) begin
            gnt_found = 1'b1;
            gnt_idx   = ID_W'(j);
         end
      end
   end

   // a grant needs a free slot: empty, or being drained this cycle
   assign slot_free   = !o_rsp_valid || i_rsp_ready;
   assign gnt_en      = !i_rst && slot_free && gnt_found;
   assign o_req_ready = gnt_en ? (NUM_REQ'(1) << gnt_idx) : '0;
   assign ptr_nxt     = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

   // the single shared adder, fed by the granted requester's operands
   assign a_sel = req_a_arr[gnt_idx];
   assign b_sel = req_b_arr[gnt_idx];
   assign sum   = a_sel + b_sel;
   assign ovf   = (a_sel[DATA_W-1] == b_sel[DATA_W-1]) && (sum[DATA_W-1] != a_sel[DATA_W-1]);

   // response slot, round-robin pointer and saturating grant counter
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_rsp_valid <= 1'b0;
         o_rsp_sum   <= '0;
         o_rsp_id    <= '0;
         o_rsp_ovf   <= 1'b0;
         o_grant_cnt <= '0;
         ptr         <= '0;
      end else if (gnt_en) begin
         o_rsp_valid <= 1'b1;
         o_rsp_sum   <= sum;
         o_rsp_id    <= gnt_idx;
         o_rsp_ovf   <= ovf;
         ptr         <= ptr_nxt;
         if (o_grant_cnt != 16'hFFFF) o_grant_cnt <= o_grant_cnt + 16'd1;
      end else if (o_rsp_valid && i_rsp_ready) begin
         o_rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter with NUM_REQ=4.
module tb_adder_rr_arbiter;

   logic         clk;
   logic         rst;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [127:0] req_a;
   logic [127:0] req_b;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [31:0]  rsp_sum;
   logic [1:0]   rsp_id;
   logic         rsp_ovf;
   logic [15:0]  grant_cnt;

   int tests;
   int fails;

   adder_rr_arbiter #(.NUM_REQ(4), .DATA_W(32)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req_a     (req_a),
      .i_req_b     (req_b),
      .o_rsp_valid (rsp_valid),
      .i_rsp_ready (rsp_ready),
      .o_rsp_sum   (rsp_sum),
      .o_rsp_id    (rsp_id),
      .o_rsp_ovf   (rsp_ovf),
      .o_grant_cnt (grant_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // operands a[k] = k*0x10, b[k] = 1 -> sums 0x01, 0x11, 0x21, 0x31
   task automatic load_rr_operands();
      for (int k = 0; k < 4; k++) begin
         req_a[k*32 +: 32] = 32'(k * 16);
         req_b[k*32 +: 32] = 32'd1;
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      req_a     = '0;
      req_b     = '0;
      tick();
      tests++;
      if (req_ready !== 4'b0000) begin
         fails++; $display("FAIL reset_ready got=%b exp=0000", req_ready);
      end
      tick();
      tests++;
      if (rsp_valid !== 1'b0 || rsp_sum !== 32'h0 || rsp_id !== 2'd0 || rsp_ovf !== 1'b0 || grant_cnt !== 16'd0) begin
         fails++;
         $display("FAIL reset_state got v=%b sum=%h id=%0d ovf=%b cnt=%0d exp all zero",
                  rsp_valid, rsp_sum, rsp_id, rsp_ovf, grant_cnt);
      end
      rst       = 1'b0;
      req_valid = '0;
      tick();
   endtask

   task automatic test_single();
      req_a[2*32 +: 32] = 32'h0000_0005;
      req_b[2*32 +: 32] = 32'h0000_0007;
      req_valid = 4'b0100;
      rsp_ready = 1'b1;
      #1;
      tests++;
      if (req_ready !== 4'b0100) begin
         fails++; $display("FAIL single_ready got=%b exp=0100", req_ready);
      end
      tick();
      req_valid = '0;
      tests++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 32'h0000_000C || rsp_id !== 2'd2 || rsp_ovf !== 1'b0) begin
         fails++;
         $display("FAIL single_rsp got v=%b sum=%h id=%0d ovf=%b exp v=1 sum=0000000c id=2 ovf=0",
                  rsp_valid, rsp_sum, rsp_id, rsp_ovf);
      end
      tick();
      tests++;
      if (rsp_valid !== 1'b0) begin
         fails++; $display("FAIL single_drain got v=%b exp=0", rsp_valid);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0]  exp_id  [6];
      logic [31:0] exp_sum [4];
      exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      exp_sum = '{32'h01, 32'h11, 32'h21, 32'h31};
      do_reset();
      load_rr_operands();
      rsp_ready = 1'b1;
      req_valid = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         #1;
         tests++;
         if (req_ready !== (4'b0001 << exp_id[i])) begin
            fails++; $display("FAIL rr_ready[%0d] got=%b exp_idx=%0d", i, req_ready, exp_id[i]);
         end
         tick();
         tests++;
         if (rsp_valid !== 1'b1 || rsp_id !== exp_id[i] || rsp_sum !== exp_sum[exp_id[i]]) begin
            fails++;
            $display("FAIL rr_rsp[%0d] got v=%b id=%0d sum=%h exp v=1 id=%0d sum=%h",
                     i, rsp_valid, rsp_id, rsp_sum, exp_id[i], exp_sum[exp_id[i]]);
         end
      end
      tests++;
      if (grant_cnt !== 16'd6) begin
         fails++; $display("FAIL rr_count got=%0d exp=6", grant_cnt);
      end
   endtask

   // continues from round robin: pending rsp id1 sum 0x11, ptr=2
   task automatic test_backpressure();
      rsp_ready = 1'b0;
      req_valid = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++;
         if (req_ready !== 4'b0000) begin
            fails++; $display("FAIL bp_ready[%0d] got=%b exp=0000", i, req_ready);
         end
         tick();
         tests++;
         if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 32'h11 || rsp_ovf !== 1'b0 || grant_cnt !== 16'd6) begin
            fails++;
            $display("FAIL bp_hold[%0d] got v=%b id=%0d sum=%h ovf=%b cnt=%0d exp v=1 id=1 sum=00000011 ovf=0 cnt=6",
                     i, rsp_valid, rsp_id, rsp_sum, rsp_ovf, grant_cnt);
         end
      end
      rsp_ready = 1'b1;
      #1;
      tests++;
      if (req_ready !== 4'b1000) begin
         fails++; $display("FAIL bp_resume_ready got=%b exp=1000", req_ready);
      end
      tick();
      tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sum !== 32'h31) begin
         fails++; $display("FAIL bp_resume_rsp got v=%b id=%0d sum=%h exp v=1 id=3 sum=00000031", rsp_valid, rsp_id, rsp_sum);
      end
      #1;
      tests++;
      if (req_ready !== 4'b0010) begin
         fails++; $display("FAIL bp_b2b_ready got=%b exp=0010", req_ready);
      end
      tick();
      tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || grant_cnt !== 16'd8) begin
         fails++; $display("FAIL bp_b2b_rsp got v=%b id=%0d cnt=%0d exp v=1 id=1 cnt=8", rsp_valid, rsp_id, grant_cnt);
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_arith();
      logic [31:0] va   [3];
      logic [31:0] vb   [3];
      logic [31:0] vsum [3];
      logic        vovf [3];
      va   = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
      vb   = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000};
      vsum = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
      vovf = '{1'b0, 1'b1, 1'b1};
      do_reset();
      rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req_a[31:0] = va[i];
         req_b[31:0] = vb[i];
         req_valid   = 4'b0001;
         tick();
         req_valid = '0;
         tests++;
         if (rsp_valid !== 1'b1 || rsp_sum !== vsum[i] || rsp_ovf !== vovf[i] || rsp_id !== 2'd0) begin
            fails++;
            $display("FAIL arith[%0d] got v=%b sum=%h ovf=%b id=%0d exp v=1 sum=%h ovf=%b id=0",
                     i, rsp_valid, rsp_sum, rsp_ovf, rsp_id, vsum[i], vovf[i]);
         end
      end
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      load_rr_operands();
      rsp_ready = 1'b1;
      req_valid = 4'b1111;
      for (int i = 0; i < 5; i++) tick();
      tests++;
      if (rsp_valid !== 1'b1 || grant_cnt !== 16'd5) begin
         fails++; $display("FAIL rmid_pre got v=%b cnt=%0d exp v=1 cnt=5", rsp_valid, grant_cnt);
      end
      rst = 1'b1;
      #1;
      tests++;
      if (req_ready !== 4'b0000) begin
         fails++; $display("FAIL rmid_ready got=%b exp=0000", req_ready);
      end
      tick();
      tests++;
      if (rsp_valid !== 1'b0 || grant_cnt !== 16'd0) begin
         fails++; $display("FAIL rmid_clear got v=%b cnt=%0d exp v=0 cnt=0", rsp_valid, grant_cnt);
      end
      rst       = 1'b0;
      req_valid = 4'b0110;
      #1;
      tests++;
      if (req_ready !== 4'b0010) begin
         fails++; $display("FAIL rmid_first got=%b exp=0010", req_ready);
      end
      tick();
      tests++;
      if (rsp_id !== 2'd1 || rsp_sum !== 32'h11 || grant_cnt !== 16'd1) begin
         fails++; $display("FAIL rmid_rsp got id=%0d sum=%h cnt=%0d exp id=1 sum=00000011 cnt=1", rsp_id, rsp_sum, grant_cnt);
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_saturation();
      do_reset();
      rsp_ready = 1'b1;
      req_valid = 4'b1111;
      for (int i = 0; i < 65535; i++) tick();
      tests++;
      if (grant_cnt !== 16'hFFFF) begin
         fails++; $display("FAIL sat_reach got=%h exp=ffff", grant_cnt);
      end
      tick();
      tick();
      tests++;
      if (grant_cnt !== 16'hFFFF || rsp_valid !== 1'b1) begin
         fails++; $display("FAIL sat_hold got cnt=%h v=%b exp cnt=ffff v=1", grant_cnt, rsp_valid);
      end
      req_valid = '0;
      tick();
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_arith();
      test_reset_mid();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
